mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one single-port unified memory between the fetch stage (instruction reads) and the memory stage (loads/stores) of the pipelined MIPS core. Multi-cycle FSM with a latency counter: it serializes accesses, buffers returned words, and raises `memstall`, which the hazard unit ORs into its stall/enable logic. When both stages request in the same cycle, the memory stage is served first.

## Interface
- `MEM_LAT`, 2: memory read latency in cycles, legal range 1..15.
- `AW`, 32: address width.
- `DW`, 32: data width.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `ifreqF` in 1: fetch stage needs the instruction at `pcF`.
- `pcF` in AW: fetch address.
- `stallF` in 1: fetch stage is held by the hazard unit for a non-memory reason.
- `dreqM` in 1: memory stage has a load/store (`memtoregM | memwriteM`).
- `memwriteM` in 1: the M-stage access is a store.
- `aluoutM` in AW: data address.
- `writedataM` in DW: store data.
- `instrF` out DW: fetched instruction.
- `readdataM` out DW: load data.
- `memstall` out 1: freeze the whole pipeline.
- `mem_req` out 1: memory access active.
- `mem_we` out 1: memory write enable.
- `mem_addr` out AW: memory address.
- `mem_wdata` out DW: memory write data.
- `mem_rdata` in DW: memory read data, valid combinationally in the MEM_LAT-th consecutive cycle of `mem_req` for one address.

## Operation
- States:
  - IDLE.
  - FETCH: serving the fetch stage.
  - DATA: serving the memory stage.
- Flags:
  - `fdone`: instruction buffered, not yet consumed.
  - `ddone`: load/store complete, not yet consumed.
- Pending conditions:
  - `fpend = ifreqF & ~fdone`.
  - `dpend = dreqM & ~ddone`.
- `memstall = ~reset & (fpend | dpend)`, adjusted by the macro (see Configuration).
- IDLE transitions:
  - to DATA if `dpend`;
  - else to FETCH if `fpend`;
  - else stay in IDLE.
- FETCH/DATA:
  - On entry, load a countdown counter with MEM_LAT-1. Counter is `$clog2(MEM_LAT)+1` bits wide.
  - Drive `mem_req=1`.
  - FETCH drives `mem_addr=pcF`, `mem_we=0`.
  - DATA drives `mem_addr=aluoutM`, `mem_we=memwriteM`, `mem_wdata=writedataM`.
  - `mem_we` stays high for every cycle of a store access. The memory tolerates repeated identical writes.
- Completion (counter == 0):
  - FETCH: latch `mem_rdata` into the `instrF` buffer; set `fdone`.
  - DATA: for a load, latch `mem_rdata` into the `readdataM` buffer; set `ddone`. A store sets only `ddone`.
- Next state at completion:
  - DATA goes directly to FETCH if `fpend`, else IDLE. No idle gap.
  - FETCH goes to DATA if `dpend`, else IDLE.
- Consumption:
  - `ddone` clears on any edge where `memstall=0`; the M stage always advances then.
  - `fdone` clears on an edge where `memstall=0 & ~stallF`.
  - If `stallF` is high, `fdone` and `instrF` are held, so no refetch occurs.
- `mem_req`/`mem_we` are 0 in IDLE. `mem_addr`/`mem_wdata` hold their last value in IDLE.
- `pcF`, `aluoutM`, `memwriteM` and `writedataM` are stable during an access because `memstall` freezes their producers.

## Timing
- Reset values:
  - State IDLE, `fdone=ddone=0`.
  - `instrF`, `readdataM`, `mem_addr`, `mem_wdata` all 0.
  - `mem_req=0`, `mem_we=0`, `memstall=0`.
- Single fetch, request seen in cycle 0 (IDLE):
  - FETCH occupies cycles 1..L, where L=MEM_LAT.
  - Capture at the end of cycle L.
  - `memstall` is high in cycles 0..L (L+1 cycles) and low in cycle L+1, with `instrF` valid.
- Simultaneous requests:
  - DATA occupies cycles 1..L, FETCH cycles L+1..2L.
  - `memstall` is low in cycle 2L+1.
- Reset mid-access: abort immediately, return to reset values, and issue no further `mem_req`. A store may be partially applied (memory-side issue, not ours).
- MEM_LAT=1: each access is one cycle, and the counter is loaded with 0.

## Configuration
- `MEM_ARB_BYPASS_EN`:
  - Defined: in the completion cycle of an access, the matching pending term is masked in `memstall`, and `instrF`/`readdataM` are driven combinationally from `mem_rdata`. The stage advances that same cycle. Single fetch stalls L cycles; simultaneous requests stall 2L cycles.
  - Undefined: outputs come only from the registered buffers, with timing as stated above.
  - The buffers and flags update identically in both builds.

## Test plan
- MEM_LAT=2, `ifreqF` only, `pcF=0x40`, memory returns `0x8C080004` -> `mem_req` high cycles 1–2 with `mem_addr=0x40`; `memstall` high cycles 0–2; `instrF=0x8C080004` in cycle 3.
- Same cycle: `ifreqF` (pc 0x44) and load `dreqM` (addr 0x100, data 0xDEADBEEF) -> DATA cycles 1–2, FETCH 3–4, `mem_addr` 0x100 then 0x44, no IDLE between; `readdataM=0xDEADBEEF` and `memstall=0` in cycle 5.
- Store `memwriteM=1`, addr 0x200, wdata 0x12345678, MEM_LAT=3 -> `mem_we=1` exactly cycles 1–3; `readdataM` unchanged; `memstall` low in cycle 4.
- Fetch completes while `stallF=1` for 3 cycles -> no second FETCH; `instrF` held; `fdone` clears on the first edge with `stallF=0`.
- `reset` asserted in cycle 2 of a 3-cycle DATA access -> next cycle IDLE, `mem_req=0`, all outputs 0, flags clear.
- With `MEM_ARB_BYPASS_EN`, MEM_LAT=2, single fetch -> `memstall` low in cycle 2 with `instrF=mem_rdata`.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: serializes fetch-stage and memory-stage accesses onto one
// single-port memory and raises memstall while either stage is waiting.
// The memory stage wins when both request in the same cycle.
// Optional build macro MEM_ARB_BYPASS_EN: forwards mem_rdata straight to
// instrF/readdataM in the completion cycle and drops that stall term early.
module mem_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ifreqF,
  input  logic [AW-1:0] pcF,
  input  logic          stallF,
  input  logic          dreqM,
  input  logic          memwriteM,
  input  logic [AW-1:0] aluoutM,
  input  logic [DW-1:0] writedataM,
  output logic [DW-1:0] instrF,
  output logic [DW-1:0] readdataM,
  output logic          memstall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(MEM_LAT) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fdone_q, fdone_d;
  logic          ddone_q, ddone_d;
  logic [DW-1:0] instr_q, instr_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic          fpend_s, dpend_s;
  logic          done_s, fcomp_s, dcomp_s;
  logic          memstall_s;

  // Pending terms, completion detection and the pipeline freeze.
  always_comb begin
    fpend_s = ifreqF & ~fdone_q;
    dpend_s = dreqM & ~ddone_q;
    done_s  = (state_q != IDLE) && (cnt_q == {CW{1'b0}});
    fcomp_s = (state_q == FETCH) && done_s;
    dcomp_s = (state_q == DATA) && done_s;
`ifdef MEM_ARB_BYPASS_EN
    // The word is forwarded this cycle, so the finishing stage need not wait.
    memstall_s = ~reset & ((fpend_s & ~fcomp_s) | (dpend_s & ~dcomp_s));
`else
    memstall_s = ~reset & (fpend_s | dpend_s);
`endif
  end

  // Next-state logic: the data side has priority; completions chain directly.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (dpend_s) begin
          state_d = DATA;
        end else if (fpend_s) begin
          state_d = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        if (done_s) begin
          if (dpend_s) begin
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = FETCH;
        end
      end
      DATA: begin
        if (done_s) begin
          if (fpend_s) begin
            state_d = FETCH;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = DATA;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Latency countdown, done flags, return buffers and registered memory port.
  always_comb begin
    cnt_d   = cnt_q;
    fdone_d = fdone_q;
    ddone_d = ddone_q;
    instr_d = instr_q;
    rdata_d = rdata_q;
    req_d   = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    // Reload on every entry into an access, including chained ones.
    if ((state_d != IDLE) && ((state_q == IDLE) || done_s)) begin
      cnt_d = CNT_LOAD;
    end else if (state_q != IDLE) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      cnt_d = cnt_q;
    end

    // Consumption wins over completion: with forwarding the stage takes the
    // word in the same cycle, so the flag must not survive that edge.
    if (~memstall_s & ~stallF) begin
      fdone_d = 1'b0;
    end else if (fcomp_s) begin
      fdone_d = 1'b1;
    end else begin
      fdone_d = fdone_q;
    end

    if (~memstall_s) begin
      ddone_d = 1'b0;
    end else if (dcomp_s) begin
      ddone_d = 1'b1;
    end else begin
      ddone_d = ddone_q;
    end

    if (fcomp_s) begin
      instr_d = mem_rdata;
    end else begin
      instr_d = instr_q;
    end

    if (dcomp_s && !memwriteM) begin
      rdata_d = mem_rdata;
    end else begin
      rdata_d = rdata_q;
    end

    // Memory port follows the state being entered; address/data hold in IDLE.
    case (state_d)
      FETCH: begin
        req_d  = 1'b1;
        addr_d = pcF;
      end
      DATA: begin
        req_d   = 1'b1;
        we_d    = memwriteM;
        addr_d  = aluoutM;
        wdata_d = writedataM;
      end
      default: begin
        req_d  = 1'b0;
        we_d   = 1'b0;
        addr_d = addr_q;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers; reset aborts any access in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= {CW{1'b0}};
      fdone_q <= 1'b0;
      ddone_q <= 1'b0;
      instr_q <= {DW{1'b0}};
      rdata_q <= {DW{1'b0}};
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= {AW{1'b0}};
      wdata_q <= {DW{1'b0}};
    end else begin
      cnt_q   <= cnt_d;
      fdone_q <= fdone_d;
      ddone_q <= ddone_d;
      instr_q <= instr_d;
      rdata_q <= rdata_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef MEM_ARB_BYPASS_EN
  assign instrF    = fcomp_s ? mem_rdata : instr_q;
  assign readdataM = (dcomp_s && !memwriteM) ? mem_rdata : rdata_q;
`else
  assign instrF    = instr_q;
  assign readdataM = rdata_q;
`endif
  assign memstall  = memstall_s;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a latency-accurate
// memory model (read data is valid only in the LAT-th cycle on one address).
module tb_mem_arbiter;

  localparam int LAT = 2;
`ifdef MEM_ARB_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk;
  logic        reset;
  logic        ifreqF;
  logic [31:0] pcF;
  logic        stallF;
  logic        dreqM;
  logic        memwriteM;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;
  logic [31:0] instrF;
  logic [31:0] readdataM;
  logic        memstall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_instr_q[$];
  logic [31:0] exp_load_q[$];
  logic [31:0] last_load;

  mem_arbiter #(.MEM_LAT(LAT), .AW(32), .DW(32)) u_dut (
    .clk(clk), .reset(reset), .ifreqF(ifreqF), .pcF(pcF), .stallF(stallF),
    .dreqM(dreqM), .memwriteM(memwriteM), .aluoutM(aluoutM), .writedataM(writedataM),
    .instrF(instrF), .readdataM(readdataM), .memstall(memstall), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- memory model ----------------
  logic [31:0] mem [0:1023];
  bit          written [0:1023];
  int          run_q;
  bit          last_req_q;
  logic [31:0] last_addr_q;
  int          cur_run;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    case (a)
      32'h0000_0040: return 32'h8C08_0004;
      32'h0000_0044: return 32'h2008_000A;
      32'h0000_0048: return 32'h3C01_1000;
      32'h0000_004C: return 32'hAC22_0008;
      32'h0000_0100: return 32'hDEAD_BEEF;
      default:       return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    if (written[a[11:2]]) return mem[a[11:2]];
    else return init_word(a);
  endfunction

  // Memory array writes and consecutive-cycle tracking.
  always @(posedge clk) begin
    if (mem_req === 1'b1 && mem_we === 1'b1) begin
      mem[mem_addr[11:2]]     <= mem_wdata;
      written[mem_addr[11:2]] <= 1'b1;
    end
    if (mem_req === 1'b1) run_q <= cur_run;
    else run_q <= 0;
    last_req_q  <= (mem_req === 1'b1);
    last_addr_q <= mem_addr;
  end

  // Read data appears only in the LAT-th consecutive cycle on one address.
  always_comb begin
    cur_run = 1;
    if (mem_req === 1'b1 && last_req_q && last_addr_q === mem_addr) cur_run = run_q + 1;
    mem_rdata = 32'hBAD0_BAD0;
    if (mem_req === 1'b1 && cur_run == LAT) mem_rdata = model_word(mem_addr);
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; ifreqF = 1'b1; dreqM = 1'b1; memwriteM = 1'b1; stallF = 1'b0;
    pcF = 32'h40; aluoutM = 32'h100; writedataM = 32'h1111_2222;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if (instrF !== 32'h0) begin n_fail++; $display("FAIL rst_instrF: got %h expected 0", instrF); end
    n_tests++; if (readdataM !== 32'h0) begin n_fail++; $display("FAIL rst_readdataM: got %h expected 0", readdataM); end
    n_tests++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); end
    n_tests++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_mem_wdata: got %h expected 0", mem_wdata); end
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %b expected 0", mem_req); end
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we: got %b expected 0", mem_we); end
    n_tests++; if (memstall !== 1'b0) begin n_fail++; $display("FAIL rst_memstall: got %b expected 0", memstall); end
    @(posedge clk); #1;
    reset = 1'b0; ifreqF = 1'b0; dreqM = 1'b0; memwriteM = 1'b0;
    @(negedge clk);
    n_tests++; if (memstall !== 1'b0) begin n_fail++; $display("FAIL idle_memstall: got %b expected 0", memstall); end
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL idle_mem_req: got %b expected 0", mem_req); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_fetch();
    logic e_stall, e_req;
    logic [31:0] e_w;
    exp_instr_q.push_back(model_word(32'h40));
    ifreqF = 1'b1; pcF = 32'h40;
    for (int c = 0; c <= LAT + 1 - BYP; c++) begin
      @(negedge clk);
      e_stall = (c <= LAT - BYP);
      e_req   = (c >= 1) && (c <= LAT);
      n_tests++; if (memstall !== e_stall) begin n_fail++; $display("FAIL fetch_memstall c=%0d: got %b expected %b", c, memstall, e_stall); end
      n_tests++; if (mem_req !== e_req) begin n_fail++; $display("FAIL fetch_mem_req c=%0d: got %b expected %b", c, mem_req, e_req); end
      if (e_req) begin
        n_tests++; if (mem_addr !== 32'h40) begin n_fail++; $display("FAIL fetch_mem_addr c=%0d: got %h expected 00000040", c, mem_addr); end
      end
      if (c == LAT + 1 - BYP) begin
        e_w = exp_instr_q.pop_front();
        n_tests++; if (instrF !== e_w) begin n_fail++; $display("FAIL fetch_instrF: got %h expected %h", instrF, e_w); end
      end
      @(posedge clk); #1;
    end
    ifreqF = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_simultaneous();
    logic e_stall, e_req;
    logic [31:0] e_addr, e_w;
    exp_load_q.push_back(model_word(32'h100));
    exp_instr_q.push_back(model_word(32'h44));
    ifreqF = 1'b1; pcF = 32'h44; dreqM = 1'b1; memwriteM = 1'b0; aluoutM = 32'h100;
    for (int c = 0; c <= 2 * LAT + 1 - BYP; c++) begin
      @(negedge clk);
      e_stall = (c <= 2 * LAT - BYP);
      e_req   = (c >= 1) && (c <= 2 * LAT);
      e_addr  = (c <= LAT) ? 32'h100 : 32'h44;
      n_tests++; if (memstall !== e_stall) begin n_fail++; $display("FAIL both_memstall c=%0d: got %b expected %b", c, memstall, e_stall); end
      n_tests++; if (mem_req !== e_req) begin n_fail++; $display("FAIL both_mem_req c=%0d: got %b expected %b", c, mem_req, e_req); end
      if (e_req) begin
        n_tests++; if (mem_addr !== e_addr) begin n_fail++; $display("FAIL both_mem_addr c=%0d: got %h expected %h", c, mem_addr, e_addr); end
      end
      if (c == 2 * LAT + 1 - BYP) begin
        e_w = exp_load_q.pop_front();
        last_load = e_w;
        n_tests++; if (readdataM !== e_w) begin n_fail++; $display("FAIL both_readdataM: got %h expected %h", readdataM, e_w); end
        e_w = exp_instr_q.pop_front();
        n_tests++; if (instrF !== e_w) begin n_fail++; $display("FAIL both_instrF: got %h expected %h", instrF, e_w); end
      end
      @(posedge clk); #1;
    end
    ifreqF = 1'b0; dreqM = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_store();
    logic e_stall, e_we;
    logic [31:0] e_w;
    dreqM = 1'b1; memwriteM = 1'b1; aluoutM = 32'h200; writedataM = 32'h1234_5678;
    for (int c = 0; c <= LAT + 1 - BYP; c++) begin
      @(negedge clk);
      e_stall = (c <= LAT - BYP);
      e_we    = (c >= 1) && (c <= LAT);
      n_tests++; if (memstall !== e_stall) begin n_fail++; $display("FAIL store_memstall c=%0d: got %b expected %b", c, memstall, e_stall); end
      n_tests++; if (mem_we !== e_we) begin n_fail++; $display("FAIL store_mem_we c=%0d: got %b expected %b", c, mem_we, e_we); end
      if (e_we) begin
        n_tests++; if (mem_addr !== 32'h200) begin n_fail++; $display("FAIL store_mem_addr c=%0d: got %h expected 00000200", c, mem_addr); end
        n_tests++; if (mem_wdata !== 32'h1234_5678) begin n_fail++; $display("FAIL store_mem_wdata c=%0d: got %h expected 12345678", c, mem_wdata); end
      end
      if (c == LAT + 1 - BYP) begin
        n_tests++; if (readdataM !== last_load) begin n_fail++; $display("FAIL store_readdataM_held: got %h expected %h", readdataM, last_load); end
      end
      @(posedge clk); #1;
    end
    dreqM = 1'b0; memwriteM = 1'b0;
    @(posedge clk); #1;
    e_w = model_word(32'h200);
    n_tests++; if (e_w !== 32'h1234_5678) begin n_fail++; $display("FAIL store_mem_content: got %h expected 12345678", e_w); end
  endtask

  task automatic test_stall_hold();
    bit got;
    logic [31:0] e_w;
    exp_instr_q.push_back(model_word(32'h48));
    ifreqF = 1'b1; pcF = 32'h48; stallF = 1'b1;
    for (int c = 0; c <= LAT + 4; c++) begin
      @(negedge clk);
      if (c >= LAT + 1) begin
        n_tests++; if (memstall !== 1'b0) begin n_fail++; $display("FAIL hold_memstall c=%0d: got %b expected 0", c, memstall); end
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL hold_refetch c=%0d: got mem_req %b expected 0", c, mem_req); end
        n_tests++; if (instrF !== exp_instr_q[0]) begin n_fail++; $display("FAIL hold_instrF c=%0d: got %h expected %h", c, instrF, exp_instr_q[0]); end
      end
      @(posedge clk); #1;
      stallF = (c + 1 <= LAT + 3);
    end
    void'(exp_instr_q.pop_front());
    pcF = 32'h4C;
    exp_instr_q.push_back(model_word(32'h4C));
    @(negedge clk);
    n_tests++; if (memstall !== 1'b1) begin n_fail++; $display("FAIL hold_fdone_cleared: got memstall %b expected 1", memstall); end
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (memstall === 1'b0) begin got = 1'b1; break; end
      @(posedge clk); #1;
      @(negedge clk);
    end
    e_w = exp_instr_q.pop_front();
    n_tests++;
    if (!got) begin n_fail++; $display("FAIL hold_second_fetch: timeout waiting for memstall low"); end
    else if (instrF !== e_w) begin n_fail++; $display("FAIL hold_second_instrF: got %h expected %h", instrF, e_w); end
    @(posedge clk); #1;
    ifreqF = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit got;
    logic [31:0] e_w;
    dreqM = 1'b1; memwriteM = 1'b1; aluoutM = 32'h300; writedataM = 32'hCAFE_F00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    n_tests++; if (memstall !== 1'b0) begin n_fail++; $display("FAIL midrst_memstall: got %b expected 0", memstall); end
    @(posedge clk); #1;
    reset = 1'b0; dreqM = 1'b0; memwriteM = 1'b0;
    @(negedge clk);
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL midrst_mem_req: got %b expected 0", mem_req); end
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL midrst_mem_we: got %b expected 0", mem_we); end
    n_tests++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL midrst_mem_addr: got %h expected 0", mem_addr); end
    n_tests++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL midrst_mem_wdata: got %h expected 0", mem_wdata); end
    n_tests++; if (instrF !== 32'h0) begin n_fail++; $display("FAIL midrst_instrF: got %h expected 0", instrF); end
    n_tests++; if (readdataM !== 32'h0) begin n_fail++; $display("FAIL midrst_readdataM: got %h expected 0", readdataM); end
    n_tests++; if (memstall !== 1'b0) begin n_fail++; $display("FAIL midrst_memstall_after: got %b expected 0", memstall); end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL midrst_no_req: got %b expected 0", mem_req); end
    @(posedge clk); #1;
    exp_load_q.push_back(model_word(32'h100));
    dreqM = 1'b1; aluoutM = 32'h100;
    @(negedge clk);
    n_tests++; if (memstall !== 1'b1) begin n_fail++; $display("FAIL midrst_ddone_cleared: got memstall %b expected 1", memstall); end
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (memstall === 1'b0) begin got = 1'b1; break; end
      @(posedge clk); #1;
      @(negedge clk);
    end
    e_w = exp_load_q.pop_front();
    n_tests++;
    if (!got) begin n_fail++; $display("FAIL midrst_load: timeout waiting for memstall low"); end
    else if (readdataM !== e_w) begin n_fail++; $display("FAIL midrst_load_readdataM: got %h expected %h", readdataM, e_w); end
    @(posedge clk); #1;
    dreqM = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; ifreqF = 1'b0; pcF = 32'h0; stallF = 1'b0; dreqM = 1'b0;
    memwriteM = 1'b0; aluoutM = 32'h0; writedataM = 32'h0; last_load = 32'h0;
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_store();
    test_stall_hold();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
